dmem_responder: RTL and testbench

//  Memory-side responder for the CPU data port: accepts one load/store request per valid/ready

---
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Purpose     : memory-side responder for the CPU data port; one load/store per handshake, word array storage.
// Latency     : accept edge N -> resp_valid high after edge N+LATENCY+1; response held until taken.
// Backpressure: req_ready low from accept until the cycle after the response handshake; resp_* stall on resp_ready.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_we, req_be, req_addr,
//   req_wdata                     store flag, byte enables, byte address, store data
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          load data or post-store word, access error flag
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag accesses whose enabled byte lanes
// run past the end of the addressed word (req_addr[1:0] offset) as errors.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int          IDX_W   = ADDR_W - 2;
  localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [3:0]  LAT4    = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, commit;

  logic              lat_we;
  logic [3:0]        lat_be;
  logic [IDX_W-1:0]  lat_idx;
  logic [31:0]       lat_wdata;

  logic              in_range, misaligned, access_err, mem_we;
  logic [MEM_AW-1:0] mem_idx;
  logic [31:0]       rd_word, merged;

  logic [31:0]       mem [DEPTH];

  // Control: WAIT always lasts LATENCY+1 cycles so the accept-to-response
  // distance is LATENCY+1 for every setting, including LATENCY=0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAT4) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Access evaluation on the latched request.
  assign mem_idx  = lat_idx[MEM_AW-1:0];
  assign in_range = (32'(lat_idx) < DEPTH_U);
  assign rd_word  = in_range ? mem[mem_idx] : 32'd0;

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] lat_off;
  logic [3:0] eff_be, bad_lanes;

  // Lanes that would spill into the next word for a given byte offset.
  always_comb begin
    eff_be = lat_we ? lat_be : 4'hF;
    case (lat_off)
      2'd1:    bad_lanes = 4'b1000;
      2'd2:    bad_lanes = 4'b1100;
      2'd3:    bad_lanes = 4'b1110;
      default: bad_lanes = 4'b0000;
    endcase
    misaligned = |(eff_be & bad_lanes);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lat_off <= 2'd0;
    else if (accept) lat_off <= req_addr[1:0];
  end
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign misaligned      = 1'b0;
`endif

  assign access_err = !in_range || misaligned;
  assign mem_we     = commit && lat_we && !access_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_be     <= 4'd0;
      lat_idx    <= '0;
      lat_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_be    <= req_be;
        lat_idx   <= req_addr[ADDR_W-1:2];
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        resp_err   <= access_err;
        resp_rdata <= access_err ? 32'd0 : (lat_we ? merged : rd_word);
      end
    end
  end

  // Array is deliberately not reset; it only changes at the commit edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .DEPTH(128), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Drives one full request/response transaction; entered and left at posedge+1.
  task automatic xact(input logic we, input logic [3:0] be, input logic [9:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    int lat;
    req_we = we; req_be = be; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat >= 50 || n >= 50) begin
      errors++;
      $display("FAIL xact_timeout addr=%h: waited req=%0d resp=%0d cycles, required < 50", addr, n, lat);
    end
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er;
    xact(1'b1, 4'hF, 10'h010, 32'hDEADBEEF, rd, er);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL store_full got=%h/%b exp=deadbeef/0", rd, er); end
    xact(1'b0, 4'h0, 10'h010, 32'h0, rd, er);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_full got=%h/%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er;
    xact(1'b1, 4'b0010, 10'h010, 32'h0000AA00, rd, er);
    checks++; if (rd !== 32'hDEADAAEF || er !== 1'b0) begin errors++; $display("FAIL store_be2 got=%h/%b exp=deadaaef/0", rd, er); end
    xact(1'b0, 4'h0, 10'h010, 32'h0, rd, er);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL load_be2 got=%h exp=deadaaef", rd); end
    xact(1'b1, 4'b0000, 10'h010, 32'h12345678, rd, er);
    checks++; if (rd !== 32'hDEADAAEF || er !== 1'b0) begin errors++; $display("FAIL store_be0 got=%h/%b exp=deadaaef/0", rd, er); end
    xact(1'b0, 4'h0, 10'h010, 32'h0, rd, er);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL load_after_be0 got=%h exp=deadaaef", rd); end
  endtask

  task automatic test_latency_hold();
    logic [31:0] rd; logic er;
    int first_vld;
    req_we = 1'b0; req_be = 4'h0; req_addr = 10'h010; req_wdata = '0; req_valid = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_before got=%b exp=1", req_ready); end
    @(posedge clk); #1;   // accept edge N
    req_valid = 1'b0;
    first_vld = 0;
    for (int e = 1; e <= 5 && first_vld == 0; e++) begin
      if (resp_valid === 1'b1) first_vld = e - 1;
      else begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_wait edge+%0d got=%b exp=0", e - 1, req_ready); end
        @(posedge clk); #1;
      end
    end
    checks++; if (first_vld != 3) begin errors++; $display("FAIL lat_resp_edge got=%0d exp=3", first_vld); end
    // Stall the response for 5 cycles with a competing store pending.
    req_we = 1'b1; req_be = 4'hF; req_addr = 10'h010; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADAAEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cyc%0d got vld=%b rd=%h err=%b rdy=%b exp 1/deadaaef/0/0",
                 c, resp_valid, resp_rdata, resp_err, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hs_cycle_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL after_hs got vld=%b rdy=%b exp 0/1", resp_valid, req_ready); end
    xact(1'b0, 4'h0, 10'h010, 32'h0, rd, er);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL stalled_req_ignored got=%h exp=deadaaef", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er;
    xact(1'b1, 4'hF, 10'h000, 32'h11223344, rd, er);
    xact(1'b1, 4'hF, 10'h1FC, 32'hA5A5A5A5, rd, er);
    checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin errors++; $display("FAIL last_word_store got=%h/%b exp=a5a5a5a5/0", rd, er); end
    xact(1'b1, 4'hF, 10'h200, 32'hCAFEF00D, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL oor_store got=%h/%b exp=0/1", rd, er); end
    xact(1'b0, 4'h0, 10'h200, 32'h0, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL oor_load got=%h/%b exp=0/1", rd, er); end
    xact(1'b0, 4'h0, 10'h000, 32'h0, rd, er);
    checks++; if (rd !== 32'h11223344 || er !== 1'b0) begin errors++; $display("FAIL word0_intact got=%h/%b exp=11223344/0", rd, er); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er;
    xact(1'b1, 4'hF, 10'h020, 32'h55AA55AA, rd, er);
    req_we = 1'b1; req_be = 4'hF; req_addr = 10'h020; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk); #1;   // accepted
    req_valid = 1'b0;
    @(posedge clk); #1;   // mid-WAIT
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wait got rdy=%b vld=%b rd=%h err=%b exp 1/0/0/0", req_ready, resp_valid, resp_rdata, resp_err);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 4'h0, 10'h020, 32'h0, rd, er);
    checks++; if (rd !== 32'h55AA55AA || er !== 1'b0) begin errors++; $display("FAIL rst_no_write got=%h/%b exp=55aa55aa/0", rd, er); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er;
`ifdef DMEM_ALIGN_CHECK_EN
    xact(1'b1, 4'hF, 10'h011, 32'h01020304, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL misalign_store got=%h/%b exp=0/1", rd, er); end
    xact(1'b0, 4'h0, 10'h010, 32'h0, rd, er);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL misalign_no_write got=%h exp=deadaaef", rd); end
    xact(1'b0, 4'h0, 10'h012, 32'h0, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL misalign_load got=%h/%b exp=0/1", rd, er); end
    xact(1'b1, 4'b0011, 10'h012, 32'h00001234, rd, er);
    checks++; if (rd !== 32'hDEAD1234 || er !== 1'b0) begin errors++; $display("FAIL offset_ok_store got=%h/%b exp=dead1234/0", rd, er); end
`else
    xact(1'b0, 4'h0, 10'h013, 32'h0, rd, er);
    checks++; if (rd !== 32'hDEADAAEF || er !== 1'b0) begin errors++; $display("FAIL lsb_ignored_load got=%h/%b exp=deadaaef/0", rd, er); end
    xact(1'b1, 4'b0001, 10'h011, 32'h00000077, rd, er);
    checks++; if (rd !== 32'hDEADAA77 || er !== 1'b0) begin errors++; $display("FAIL lsb_ignored_store got=%h/%b exp=deadaa77/0", rd, er); end
`endif
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_latency_hold();
    test_out_of_range();
    test_reset_mid_wait();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
